pv_bin_freq: RTL
================

# pv_bin_freq

Streaming phase-vocoder frequency estimator, parametrised in FFT size, hop size, phase width and output precision. It accepts one wrapped phase per FFT bin, in bin order, every frame. It keeps the previous frame's phases internally, so callers no longer supply `last_phase`. For every bin it emits the true instantaneous frequency in fixed-point bins. It also reports the bin selected by `k_max` as the fundamental. It sits between the FFT/CORDIC phase stage and the pitch-shift resynthesis stage.

## Interface
- `PHASE_W`, 24: phase width; unsigned turns, full scale = 2π.
- `LOG2_N`, 10: log2 of FFT size N. Bins per frame `NB = 2^(LOG2_N-1)`.
- `LOG2_HOP`, 8: log2 of hop size. `OVS = LOG2_N-LOG2_HOP` must be ≥ 1.
- `FREQ_FRAC`, 8: fractional bits of the frequency output. Requires `PHASE_W ≥ FREQ_FRAC+OVS`.
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `phase` in PHASE_W: phase of the current bin.
- `phase_valid` in 1: `phase` is valid this cycle.
- `frame_start` in 1: qualified by `phase_valid`; this beat is bin 0.
- `k_max` in LOG2_N-1: fundamental bin index.
- `k_max_valid` in 1: loads `k_max` into the shadow register.
- `freq` out LOG2_N+1+FREQ_FRAC: signed frequency in bins, Q(LOG2_N+1).FREQ_FRAC.
- `freq_bin` out LOG2_N-1: bin index of `freq`.
- `freq_valid` out 1: `freq`/`freq_bin` valid.
- `first_frame` out 1: `freq` comes from a frame with no predecessor.
- `fundamental` out same as `freq`: `freq` of the active k_max bin.
- `fundamental_valid` out 1: one-cycle pulse.
- `sync_error` out 1: one-cycle pulse; `frame_start` arrived mid-frame.

## Operation
- **Bin counter `k`**
  - Advances on each `phase_valid` beat.
  - Wraps from NB-1 to 0; the wrap starts a new frame.
  - `phase_valid & frame_start` forces k=0.
  - If k≠0 at that point, `sync_error` pulses (3 cycles later, aligned with the beat's output).
  - `frame_start` without `phase_valid` is ignored.
- **Phase memory**
  - NB×PHASE_W, read-first.
  - Each beat reads `last = mem[k]` and writes `mem[k] = phase` in the same cycle.
  - Contents are not reset.
- **Arithmetic**, all mod 2^PHASE_W:
  - `exp = k << (PHASE_W-OVS)`.
  - `d = phase - last - exp`, reinterpreted as signed. This gives the wrap to [-π,π) for free.
  - `freq = (k << FREQ_FRAC) + (d >>> (PHASE_W-FREQ_FRAC-OVS))`: arithmetic shift, truncation toward -∞.
  - No multipliers; the output cannot overflow.
- **First frame**
  - `first_frame` is set by reset.
  - While it is set, d is forced to 0, so `freq = k<<FREQ_FRAC`.
  - It clears when the beat with k=NB-1 is accepted; it clears for that beat's successors, not for the beat itself.
  - A `sync_error` restart does not re-set it.
- **Fundamental**
  - `k_max_valid` loads the shadow register.
  - Shadow copies to active on the next accepted bin-0 beat, whether forced or wrapped.
  - When an output has `freq_bin == active`, `fundamental` ← `freq` and `fundamental_valid` pulses in the same cycle.
  - `fundamental` holds its value between pulses.

## Timing
- Three-stage pipeline; fixed latency 3 cycles from `phase_valid` to `freq_valid`.
  - S0: register inputs and issue the RAM read.
  - S1: compute d.
  - S2: scale, add, register outputs.
- Full throughput: one beat per cycle; gaps allowed anywhere; no backpressure.
- Reset values:
  - k=0; all pipeline valids 0.
  - `freq`, `freq_bin`, `fundamental` = 0.
  - `freq_valid`, `fundamental_valid`, `sync_error` = 0.
  - `first_frame` = 1; shadow and active k_max = 0.
- Reset asserted mid-frame discards in-flight beats. The frame after release is treated as a first frame.
- Same-cycle `k_max_valid` and bin-0 beat: the new value takes effect this frame.

## Structure
- Package `pv_pkg`:
  - Derived constants `NB`, `OVS`, `FREQ_W`.
  - Typedefs `phase_t`, `bin_t`, `freq_t`.
  - `sat`-free shift helper functions.
- Sub-module `pv_phase_ram`: simple dual-port, read-first, synchronous read, inferable as BRAM.
- Top level holds the counter, frame/first-frame control, k_max registers and the pipeline.

## Test plan
Defaults: N=1024, hop=256, PHASE_W=24, FREQ_FRAC=8. Shift amount = 14; exp(bin 1) = 0x400000.
- **First frame after reset:** frame of all phases 0x123456 → freq = k·256, `first_frame`=1 throughout. Bin 20 → 5120.
- **On-bin tone:** frame 1 all 0; frame 2 bin k phase = (k<<22) mod 2^24 → every freq = k·256 exactly, `first_frame`=0.
- **Off-bin deviation and wrap:** frame 1 bin 20 = 0; frame 2 bin 20 phase values and required freq:
  - 0x080000 → 5152
  - 0xF80000 → 5088
  - 0x7FFFFF → 5631
  - 0x800000 → 4608
- **Fundamental:**
  - `k_max`=20 loaded mid-frame 2 → no pulse at bin 20 in frame 2.
  - Frame 3 → one `fundamental_valid` with `fundamental` = freq of bin 20.
  - Same-cycle load with the bin-0 beat → pulse in that frame.
- **Sync error:** `frame_start` on the 100th beat of a frame → `sync_error` pulses with that beat's output. That output has `freq_bin`=0; later bins count 1, 2, …
- **Gapped input and reset mid-frame:**
  - Random `phase_valid` gaps → outputs identical to the gapless run, each 3 cycles after its beat.
  - `reset_n` low at bin 300 → outputs cleared; the next frame shows `first_frame`=1.

Source files
------------

// File: rtl/pv_bin_freq_pkg.sv
// pv_bin_freq shared configuration, types and shift helpers.
// Derived sizes follow from FFT size, hop size and output precision.
package pv_pkg;

   localparam int PHASE_W   = 24;
   localparam int LOG2_N    = 10;
   localparam int LOG2_HOP  = 8;
   localparam int FREQ_FRAC = 8;

   localparam int NB     = 2 ** (LOG2_N - 1);
   localparam int OVS    = LOG2_N - LOG2_HOP;
   localparam int FREQ_W = LOG2_N + 1 + FREQ_FRAC;
   localparam int D_SH   = PHASE_W - FREQ_FRAC - OVS;

   typedef logic [PHASE_W-1:0]       phase_t;
   typedef logic [LOG2_N-2:0]        bin_t;
   typedef logic signed [FREQ_W-1:0] freq_t;

   typedef struct packed {
      logic valid;
      logic sync;
      logic first;
      logic fund;
      bin_t k;
   } tag_t;

   // Expected per-hop phase advance of bin k, mod 2^PHASE_W.
   function automatic phase_t exp_phase(bin_t k);
      return phase_t'(k) << (PHASE_W - OVS);
   endfunction

   // Bin index as a fixed-point frequency.
   function automatic freq_t bin_freq(bin_t k);
      return freq_t'(k) << FREQ_FRAC;
   endfunction

   // Signed phase deviation scaled to bins, floor rounding.
   function automatic freq_t dev_freq(phase_t d);
      return freq_t'($signed(d) >>> D_SH);
   endfunction

endpackage

// File: rtl/pv_bin_freq_if.sv
// pv_bin_freq stream bundle: phase beats in, frequency beats out.
// master drives phases, slave is the estimator.
interface pv_bin_freq_if;
   import pv_pkg::*;

   phase_t phase;
   logic   phase_valid;
   logic   frame_start;
   bin_t   k_max;
   logic   k_max_valid;
   freq_t  freq;
   bin_t   freq_bin;
   logic   freq_valid;
   logic   first_frame;
   freq_t  fundamental;
   logic   fundamental_valid;
   logic   sync_error;

   modport master (
      output phase, phase_valid, frame_start, k_max, k_max_valid,
      input  freq, freq_bin, freq_valid, first_frame,
      input  fundamental, fundamental_valid, sync_error
   );

   modport slave (
      input  phase, phase_valid, frame_start, k_max, k_max_valid,
      output freq, freq_bin, freq_valid, first_frame,
      output fundamental, fundamental_valid, sync_error
   );

endinterface

// File: rtl/pv_phase_ram.sv
// pv_bin_freq previous-frame phase store.
// Simple dual-port, read-first, synchronous read; no reset.
module pv_phase_ram
   import pv_pkg::*;
(
   input  logic   clk_i,
   input  logic   we_i,
   input  bin_t   waddr_i,
   input  phase_t wdata_i,
   input  logic   re_i,
   input  bin_t   raddr_i,
   output phase_t rdata_o
);

   phase_t mem_q [NB];

   // Read returns the old word when both ports hit one address.
   always_ff @(posedge clk_i) begin
      if (re_i) rdata_o <= mem_q[raddr_i];
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

endmodule

// File: rtl/pv_bin_freq.sv
// pv_bin_freq phase-vocoder instantaneous frequency estimator.
// S0 captures beat and reads RAM, S1 forms d, S2 scales and outputs.
module pv_bin_freq
   import pv_pkg::*;
(
   input  logic         clock,
   input  logic         reset_n,
   pv_bin_freq_if.slave bus
);

   logic   beat;
   logic   start;
   bin_t   k_q, k_d;
   bin_t   shadow_q, active_q, active_d;
   logic   first_q;
   tag_t   t0_q, t0_d, t1_q;
   phase_t ph0_q, last;
   phase_t d1_q, d_d;
   freq_t  freq_d;

   freq_t  freq_q, fund_q;
   bin_t   bin_q;
   logic   fv_q, ffrm_q, fundv_q, sync_q;

   // Bin index, fundamental selection and S0 tag for this beat.
   always_comb begin
      beat     = bus.phase_valid;
      start    = beat & bus.frame_start;
      k_d      = start ? '0 : k_q;
      active_d = active_q;
      if (beat && k_d == '0)
         active_d = bus.k_max_valid ? bus.k_max : shadow_q;
      t0_d.valid = beat;
      t0_d.sync  = start && (k_q != '0);
      t0_d.first = first_q;
      t0_d.fund  = (k_d == active_d);
      t0_d.k     = k_d;
   end

   // Deviation from expected advance; frozen at zero without history.
   always_comb begin
      d_d = ph0_q - last - exp_phase(t0_q.k);
      if (t0_q.first) d_d = '0;
      freq_d = bin_freq(t1_q.k) + dev_freq(d1_q);
   end

   pv_phase_ram u_ram (
      .clk_i   (clock),
      .we_i    (beat),
      .waddr_i (k_d),
      .wdata_i (bus.phase),
      .re_i    (beat),
      .raddr_i (k_d),
      .rdata_o (last)
   );

   // Bin counter, first-frame flag and k_max shadow/active pair.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         k_q      <= '0;
         first_q  <= 1'b1;
         shadow_q <= '0;
         active_q <= '0;
      end else begin
         active_q <= active_d;
         if (bus.k_max_valid) shadow_q <= bus.k_max;
         if (beat) begin
            k_q <= k_d + bin_t'(1);
            if (k_d == bin_t'(NB - 1)) first_q <= 1'b0;
         end
      end
   end

   // S0 and S1 pipeline registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         t0_q  <= '0;
         t1_q  <= '0;
         ph0_q <= '0;
         d1_q  <= '0;
      end else begin
         t0_q <= t0_d;
         t1_q <= t0_q;
         d1_q <= d_d;
         if (beat) ph0_q <= bus.phase;
      end
   end

   // S2 output registers; fundamental holds between pulses.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         freq_q  <= '0;
         bin_q   <= '0;
         fund_q  <= '0;
         fv_q    <= 1'b0;
         ffrm_q  <= 1'b1;
         fundv_q <= 1'b0;
         sync_q  <= 1'b0;
      end else begin
         fv_q    <= t1_q.valid;
         sync_q  <= t1_q.valid & t1_q.sync;
         fundv_q <= t1_q.valid & t1_q.fund;
         if (t1_q.valid) begin
            freq_q <= freq_d;
            bin_q  <= t1_q.k;
            ffrm_q <= t1_q.first;
            if (t1_q.fund) fund_q <= freq_d;
         end
      end
   end

   assign bus.freq              = freq_q;
   assign bus.freq_bin          = bin_q;
   assign bus.freq_valid        = fv_q;
   assign bus.first_frame       = ffrm_q;
   assign bus.fundamental       = fund_q;
   assign bus.fundamental_valid = fundv_q;
   assign bus.sync_error        = sync_q;

endmodule
